ovl_window_checker: RTL and testbench

Synthesizable window-assertion checker for the shared OVL-style verification library. After a start event, it requires `test_expr` to stay TRUE on every cycle until and including the end event. It reports each violation as a registered one-cycle `fire` pulse and accumulates a saturating violation count. It is instantiated in block-level benches alongside the shared 100 MHz clock generator and observes the signals it is given without driving them.

---
 rtl/ovl_window_checker.sv | 124 ++++++++++++
 tb/tb_ovl_window_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovl_window_checker.sv
// ---------------------------------------------------------------------------
// ovl_window_checker
//
// Window assertion checker. A start event opens a window. While the window
// is open, test_expr must be TRUE on every enabled cycle, up to and including
// the cycle that carries the end event. Each violation produces a registered
// one-cycle fire pulse and bumps a saturating violation counter.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high; overrides everything
//   enable       in   1 = checking active, 0 = freeze state and counter
//   test_expr    in   expression that must be TRUE inside the window
//   start_event  in   level-sampled, opens the window from IDLE
//   end_event    in   level-sampled, closes the window (cycle still checked)
//   fire         out  registered one-cycle violation pulse
//   window_open  out  registered, 1 while the FSM is in OPEN
//   err_count    out  saturating violation count, ERR_CNT_W bits
//
// Optional feature: define OVL_WINDOW_MSG_EN to print a simulation message
// for every violation. That code is simulation-only and is excluded
// whenever SYNTHESIS is defined. Port behaviour is the same either way.
// ---------------------------------------------------------------------------
module ovl_window_checker #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 test_expr,
    input  logic                 start_event,
    input  logic                 end_event,
    output logic                 fire,
    output logic                 window_open,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   viol_s;
    logic                   fire_r;
    logic [ERR_CNT_W-1:0]   err_cnt_r;
    logic [ERR_CNT_W-1:0]   err_cnt_next_s;

    // Next-state and violation detection. An unknown test_expr is not a
    // proven TRUE, so anything other than a clean 1 counts as a violation.
    always_comb begin
        state_next_s = state_r;
        viol_s       = 1'b0;
        if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (start_event) begin
                        state_next_s = ST_OPEN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_OPEN: begin
                    viol_s = (test_expr !== 1'b1);
                    if (end_event) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_OPEN;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Saturating counter update: stick at all-ones rather than wrapping.
    always_comb begin
        err_cnt_next_s = err_cnt_r;
        if (viol_s && (err_cnt_r != CNT_MAX)) begin
            err_cnt_next_s = err_cnt_r + CNT_ONE;
        end else begin
            err_cnt_next_s = err_cnt_r;
        end
    end

    // State, fire pulse and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            fire_r    <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            state_r   <= state_next_s;
            fire_r    <= viol_s;
            err_cnt_r <= err_cnt_next_s;
        end
    end

    assign fire        = fire_r;
    assign window_open = (state_r == ST_OPEN);
    assign err_count   = err_cnt_r;

`ifdef OVL_WINDOW_MSG_EN
`ifndef SYNTHESIS
    // Simulation-only violation message at the sampling edge.
    always @(posedge clock) begin
        if (!reset && viol_s) begin
            $display("%0t %m: test_expr FALSE inside window", $time);
        end
    end
`endif
`else
    // Silent build: violations are reported only through fire and err_count.
`endif

endmodule

// File: tb/tb_ovl_window_checker.sv
// ---------------------------------------------------------------------------
// tb_ovl_window_checker
//
// Directed bench for ovl_window_checker. Two instances share all inputs:
// dut (ERR_CNT_W=16) and dut_sat (ERR_CNT_W=2) for the saturation scenario.
// Inputs are driven 1 time unit after a rising edge; outputs are compared
// 1 time unit after the next rising edge, so every comparison reflects the
// inputs that edge sampled.
// ---------------------------------------------------------------------------
module tb_ovl_window_checker;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        test_expr;
    logic        start_event;
    logic        end_event;
    logic        fire;
    logic        window_open;
    logic [15:0] err_count;
    logic        fire2;
    logic        window_open2;
    logic [1:0]  err_count2;

    int errors;
    int checks;

    ovl_window_checker #(.ERR_CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .test_expr   (test_expr),
        .start_event (start_event),
        .end_event   (end_event),
        .fire        (fire),
        .window_open (window_open),
        .err_count   (err_count)
    );

    ovl_window_checker #(.ERR_CNT_W(2)) dut_sat (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .test_expr   (test_expr),
        .start_event (start_event),
        .end_event   (end_event),
        .fire        (fire2),
        .window_open (window_open2),
        .err_count   (err_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock edge and settle past it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start_event = 1'b0; end_event = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            reset       = 1'b1;
            enable      = 1'b1;
            start_event = 1'($urandom_range(0, 1));
            end_event   = 1'($urandom_range(0, 1));
            test_expr   = 1'($urandom_range(0, 1));
            cyc();
            checks++;
            if (fire !== 1'b0 || window_open !== 1'b0 || err_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got fire=%b wo=%b cnt=%0d exp 0/0/0",
                         i, fire, window_open, err_count);
            end
            checks++;
            if (fire2 !== 1'b0 || window_open2 !== 1'b0 || err_count2 !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold_sat cyc=%0d got fire=%b wo=%b cnt=%0d exp 0/0/0",
                         i, fire2, window_open2, err_count2);
            end
        end
        reset = 1'b0; start_event = 1'b0; end_event = 1'b0;
    endtask

    // Window: start, then 6 open cycles with end in the 6th, test_expr = tv.
    task automatic test_window(input logic tv);
        int exp_cnt;
        do_reset();
        enable = 1'b1; test_expr = tv;
        start_event = 1'b1;
        cyc();
        start_event = 1'b0;
        checks++;
        if (window_open !== 1'b1 || fire !== 1'b0) begin
            errors++;
            $display("FAIL win%0b_open got wo=%b fire=%b exp wo=1 fire=0", tv, window_open, fire);
        end
        for (int i = 0; i < 6; i++) begin
            end_event = (i == 5);
            cyc();
            exp_cnt = tv ? 0 : i + 1;
            checks++;
            if (fire !== ~tv || err_count !== 16'(exp_cnt) || window_open !== (i < 5)) begin
                errors++;
                $display("FAIL win%0b_cyc%0d got fire=%b cnt=%0d wo=%b exp fire=%b cnt=%0d wo=%b",
                         tv, i, fire, err_count, window_open, ~tv, exp_cnt, (i < 5));
            end
        end
        end_event = 1'b0;
        cyc();
        checks++;
        if (fire !== 1'b0 || window_open !== 1'b0 || err_count !== 16'(tv ? 0 : 6)) begin
            errors++;
            $display("FAIL win%0b_final got fire=%b wo=%b cnt=%0d exp fire=0 wo=0 cnt=%0d",
                     tv, fire, window_open, err_count, (tv ? 0 : 6));
        end
    endtask

    task automatic test_disable();
        int  exp_cnt;
        logic exp_fire;
        do_reset();
        enable = 1'b1; test_expr = 1'b0;
        start_event = 1'b1;
        cyc();
        start_event = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            enable    = !(i == 2 || i == 3);
            end_event = (i == 5);
            cyc();
            exp_fire = enable;
            if (enable) exp_cnt++;
            checks++;
            if (fire !== exp_fire || err_count !== 16'(exp_cnt) || window_open !== (i < 5)) begin
                errors++;
                $display("FAIL disable_cyc%0d got fire=%b cnt=%0d wo=%b exp fire=%b cnt=%0d wo=%b",
                         i, fire, err_count, window_open, exp_fire, exp_cnt, (i < 5));
            end
        end
        end_event = 1'b0; enable = 1'b1;
        cyc();
        checks++;
        if (err_count !== 16'd4 || window_open !== 1'b0) begin
            errors++;
            $display("FAIL disable_final got cnt=%0d wo=%b exp cnt=4 wo=0", err_count, window_open);
        end
    endtask

    task automatic test_corners();
        do_reset();
        enable = 1'b1;
        // start and end together while IDLE: window opens
        start_event = 1'b1; end_event = 1'b1; test_expr = 1'b1;
        cyc();
        checks++;
        if (window_open !== 1'b1 || fire !== 1'b0) begin
            errors++;
            $display("FAIL corner_start_end got wo=%b fire=%b exp wo=1 fire=0", window_open, fire);
        end
        // end while OPEN with a violation: checked and closed
        start_event = 1'b0; end_event = 1'b1; test_expr = 1'b0;
        cyc();
        checks++;
        if (window_open !== 1'b0 || fire !== 1'b1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL corner_end_checked got wo=%b fire=%b cnt=%0d exp wo=0 fire=1 cnt=1",
                     window_open, fire, err_count);
        end
        // start right after close reopens; IDLE ignores test_expr
        start_event = 1'b1; end_event = 1'b0;
        cyc();
        checks++;
        if (window_open !== 1'b1 || fire !== 1'b0 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL corner_reopen got wo=%b fire=%b cnt=%0d exp wo=1 fire=0 cnt=1",
                     window_open, fire, err_count);
        end
        // start ignored while OPEN; violation counted
        cyc();
        checks++;
        if (window_open !== 1'b1 || fire !== 1'b1 || err_count !== 16'd2) begin
            errors++;
            $display("FAIL corner_no_rearm got wo=%b fire=%b cnt=%0d exp wo=1 fire=1 cnt=2",
                     window_open, fire, err_count);
        end
        // reset mid-window wins over everything
        start_event = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (window_open !== 1'b0 || fire !== 1'b0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL corner_mid_reset got wo=%b fire=%b cnt=%0d exp 0/0/0",
                     window_open, fire, err_count);
        end
    endtask

    // start and end held high: window alternates open/closed every cycle.
    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1; test_expr = 1'b1;
        start_event = 1'b1; end_event = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (window_open !== ((i % 2) == 0) || fire !== 1'b0) begin
                errors++;
                $display("FAIL b2b_cyc%0d got wo=%b fire=%b exp wo=%b fire=0",
                         i, window_open, fire, ((i % 2) == 0));
            end
        end
        start_event = 1'b0; end_event = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        enable = 1'b1; test_expr = 1'b0;
        start_event = 1'b1;
        cyc();
        start_event = 1'b0;
        for (int i = 0; i < 6; i++) begin
            end_event = (i == 5);
            cyc();
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            checks++;
            if (fire2 !== 1'b1 || err_count2 !== 2'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_cyc%0d got fire=%b cnt=%0d exp fire=1 cnt=%0d",
                         i, fire2, err_count2, exp_cnt);
            end
        end
        end_event = 1'b0;
        cyc();
        checks++;
        if (err_count2 !== 2'd3 || fire2 !== 1'b0 || window_open2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_final got cnt=%0d fire=%b wo=%b exp cnt=3 fire=0 wo=0",
                     err_count2, fire2, window_open2);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; enable = 1'b1; test_expr = 1'b1;
        start_event = 1'b0; end_event = 1'b0;
        #1;
        test_reset();
        test_window(1'b0);
        test_window(1'b1);
        test_disable();
        test_corners();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
